// File: rtl/ctrl_pkg.sv
// Shared types for the MicroUAZ8 instruction sequencer: FSM states,
// jump-control (CJ) codes and opcode-class encodings.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WAIT_ALU  = 3'd2,
    ST_OPERAND   = 3'd3,
    ST_WRITE_IMM = 3'd4,
    ST_HALT      = 3'd5,
    ST_STEP      = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_ALU     = 3'd1,
    CLS_LDI     = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

  localparam logic [3:0] CJ_HOLD   = 4'b0000;
  localparam logic [3:0] CJ_INC    = 4'b0001;
  localparam logic [3:0] CJ_JMP    = 4'b1000;
  localparam logic [3:0] CJ_JMP_F0 = 4'b1010;
  localparam logic [3:0] CJ_JMP_F2 = 4'b1100;
  localparam logic [3:0] CJ_JMP_F1 = 4'b1110;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_ALU  = 4'h1;
  localparam logic [3:0] OPC_LDI  = 4'h2;
  localparam logic [3:0] OPC_HALT = 4'h7;

endpackage

// File: rtl/seq_ctrl_op_decode.sv
// Combinational opcode classifier: IR[7:4] -> op_class_e.
// Jump opcodes (0x8..0xF) carry their CJ code directly in the opcode nibble.
module op_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opc_i,
  output logic [2:0] cls_o
);

  always_comb begin
    cls_o = CLS_ILLEGAL;
    if (opc_i[3]) begin
      cls_o = CLS_JUMP;
    end else begin
      case (opc_i)
        OPC_NOP:  cls_o = CLS_NOP;
        OPC_ALU:  cls_o = CLS_ALU;
        OPC_LDI:  cls_o = CLS_LDI;
        OPC_HALT: cls_o = CLS_HALT;
        default:  cls_o = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// MicroUAZ8 instruction sequencer: fetch/decode FSM driving CJ, ALU start and register writes.
// Optional single-step gate after each retired instruction: SEQ_CTRL_SINGLE_STEP_EN.
module seq_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] i_Instr,
  input  logic       i_Stall,
  input  logic       i_Alu_Done,
`ifdef SEQ_CTRL_SINGLE_STEP_EN
  input  logic       i_Step,
`endif
  output logic [3:0] o_CJ,
  output logic [7:0] o_IR,
  output logic [7:0] o_Imm,
  output logic       o_Alu_Start,
  output logic       o_Reg_We,
  output logic       o_Wr_Sel,
  output logic       o_Illegal,
  output logic       o_Halted
);

  localparam logic [3:0] TMO = 4'(ALU_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] cls;

  logic [3:0] cj;
  logic       alu_start, reg_we, wr_sel, illegal, halted, retire;

  op_decode u_op_decode (
    .opc_i (ir_q[7:4]),
    .cls_o (cls)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_FETCH;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    cnt_d     = cnt_q;
    cj        = CJ_HOLD;
    alu_start = 1'b0;
    reg_we    = 1'b0;
    wr_sel    = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    retire    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (!i_Stall) begin
          ir_d    = i_Instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (cls)
          CLS_NOP:  begin cj = CJ_INC; retire = 1'b1; end
          CLS_JUMP: begin cj = ir_q[7:4]; retire = 1'b1; end
          CLS_ALU: begin
            alu_start = 1'b1;
            cnt_d     = 4'd0;
            state_d   = ST_WAIT_ALU;
          end
          CLS_LDI: begin
            cj      = CJ_INC;
            state_d = ST_OPERAND;
          end
          CLS_HALT: state_d = ST_HALT;
          default: begin
            illegal = 1'b1;
            cj      = CJ_INC;
            retire  = 1'b1;
          end
        endcase
      end
      ST_WAIT_ALU: begin
        cnt_d = cnt_q + 4'd1;
        // done is checked first so a result arriving on the timeout cycle is kept
        if (i_Alu_Done) begin
          reg_we = 1'b1;
          cj     = CJ_INC;
          retire = 1'b1;
        end else if (cnt_q == TMO) begin
          illegal = 1'b1;
          cj      = CJ_INC;
          retire  = 1'b1;
        end
      end
      ST_OPERAND: begin
        if (!i_Stall) begin
          imm_d   = i_Instr;
          state_d = ST_WRITE_IMM;
        end
      end
      ST_WRITE_IMM: begin
        reg_we = 1'b1;
        wr_sel = 1'b1;
        cj     = CJ_INC;
        retire = 1'b1;
      end
      ST_HALT: halted = 1'b1;
`ifdef SEQ_CTRL_SINGLE_STEP_EN
      ST_STEP: begin
        if (i_Step) state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_FETCH;
    endcase

    if (retire) begin
`ifdef SEQ_CTRL_SINGLE_STEP_EN
      state_d = ST_STEP;
`else
      state_d = ST_FETCH;
`endif
    end
  end

  // Outputs are gated while reset is held so an abandoned instruction cannot write.
  assign o_CJ        = Rst ? cj : CJ_HOLD;
  assign o_Alu_Start = Rst & alu_start;
  assign o_Reg_We    = Rst & reg_we;
  assign o_Wr_Sel    = Rst & wr_sel;
  assign o_Illegal   = Rst & illegal;
  assign o_Halted    = Rst & halted;
  assign o_IR        = ir_q;
  assign o_Imm       = imm_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: per-cycle vector table plus hand sequences for
// ALU timeout, done-on-timeout, HALT and reset during an ALU wait.
module tb_seq_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [7:0] i_Instr = 8'h00;
  logic       i_Stall = 1'b0;
  logic       i_Alu_Done = 1'b0;
  logic [3:0] o_CJ;
  logic [7:0] o_IR, o_Imm;
  logic       o_Alu_Start, o_Reg_We, o_Wr_Sel, o_Illegal, o_Halted;

  int total = 0;
  int bad   = 0;
  int row   = 0;

  always #5 Clk = ~Clk;

  seq_ctrl #(.ALU_TIMEOUT(15)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .i_Instr     (i_Instr),
    .i_Stall     (i_Stall),
    .i_Alu_Done  (i_Alu_Done),
`ifdef SEQ_CTRL_SINGLE_STEP_EN
    .i_Step      (1'b1),
`endif
    .o_CJ        (o_CJ),
    .o_IR        (o_IR),
    .o_Imm       (o_Imm),
    .o_Alu_Start (o_Alu_Start),
    .o_Reg_We    (o_Reg_We),
    .o_Wr_Sel    (o_Wr_Sel),
    .o_Illegal   (o_Illegal),
    .o_Halted    (o_Halted)
  );

  typedef struct {
    logic       rst;
    logic [7:0] instr;
    logic       stall;
    logic       done;
    logic [3:0] cj;
    logic       st;
    logic       we;
    logic       ws;
    logic       ill;
    logic       hlt;
    logic [7:0] ir;
    logic [7:0] imm;
  } vec_t;

  function automatic vec_t v(logic rst, logic [7:0] instr, logic stall, logic done,
                             logic [3:0] cj, logic st, logic we, logic ws, logic ill,
                             logic hlt, logic [7:0] ir, logic [7:0] imm);
    vec_t r;
    r.rst = rst; r.instr = instr; r.stall = stall; r.done = done;
    r.cj = cj; r.st = st; r.we = we; r.ws = ws; r.ill = ill; r.hlt = hlt;
    r.ir = ir; r.imm = imm;
    return r;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, compare outputs mid-cycle.
  task automatic run_vec(vec_t t);
    @(posedge Clk);
    #1;
    Rst = t.rst; i_Instr = t.instr; i_Stall = t.stall; i_Alu_Done = t.done;
    #4;
    chk("cj",    {4'h0, o_CJ}, {4'h0, t.cj});
    chk("start", {7'h0, o_Alu_Start}, {7'h0, t.st});
    chk("we",    {7'h0, o_Reg_We}, {7'h0, t.we});
    chk("wrsel", {7'h0, o_Wr_Sel}, {7'h0, t.ws});
    chk("ill",   {7'h0, o_Illegal}, {7'h0, t.ill});
    chk("halt",  {7'h0, o_Halted}, {7'h0, t.hlt});
    chk("ir",    o_IR, t.ir);
    chk("imm",   o_Imm, t.imm);
    row++;
  endtask

  vec_t tbl[$];

  initial begin
    //            rst instr stl dn  cj   st we ws il ht  ir     imm
    tbl.push_back(v(0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(v(0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    // NOP stream: 0000/0001 with 2-cycle period
    tbl.push_back(v(1, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(v(1, 8'h00, 0, 0, 4'h1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(v(1, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(v(1, 8'h00, 0, 0, 4'h1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    // ALU, done three cycles after start
    tbl.push_back(v(1, 8'h12, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(v(1, 8'h12, 0, 0, 4'h0, 1, 0, 0, 0, 0, 8'h12, 8'h00));
    tbl.push_back(v(1, 8'h12, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h12, 8'h00));
    tbl.push_back(v(1, 8'h12, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h12, 8'h00));
    tbl.push_back(v(1, 8'h12, 0, 1, 4'h1, 0, 1, 0, 0, 0, 8'h12, 8'h00));
    // LDI 0x25, operand 0xA5 stalled two cycles
    tbl.push_back(v(1, 8'h25, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h12, 8'h00));
    tbl.push_back(v(1, 8'h25, 0, 0, 4'h1, 0, 0, 0, 0, 0, 8'h25, 8'h00));
    tbl.push_back(v(1, 8'hA5, 1, 0, 4'h0, 0, 0, 0, 0, 0, 8'h25, 8'h00));
    tbl.push_back(v(1, 8'hA5, 1, 0, 4'h0, 0, 0, 0, 0, 0, 8'h25, 8'h00));
    tbl.push_back(v(1, 8'hA5, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h25, 8'h00));
    tbl.push_back(v(1, 8'hA5, 0, 0, 4'h1, 0, 1, 1, 0, 0, 8'h25, 8'hA5));
    // stalled fetch, then conditional and unconditional jumps, illegal, 0xF jump
    tbl.push_back(v(1, 8'h83, 1, 0, 4'h0, 0, 0, 0, 0, 0, 8'h25, 8'hA5));
    tbl.push_back(v(1, 8'hA3, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h25, 8'hA5));
    tbl.push_back(v(1, 8'hA3, 0, 0, 4'hA, 0, 0, 0, 0, 0, 8'hA3, 8'hA5));
    tbl.push_back(v(1, 8'h83, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'hA3, 8'hA5));
    tbl.push_back(v(1, 8'h83, 0, 0, 4'h8, 0, 0, 0, 0, 0, 8'h83, 8'hA5));
    tbl.push_back(v(1, 8'h50, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h83, 8'hA5));
    tbl.push_back(v(1, 8'h50, 0, 0, 4'h1, 0, 0, 0, 1, 0, 8'h50, 8'hA5));
    tbl.push_back(v(1, 8'hF0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h50, 8'hA5));
    tbl.push_back(v(1, 8'hF0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 8'hF0, 8'hA5));

    foreach (tbl[i]) run_vec(tbl[i]);

    // ALU with no done: fifteen quiet wait cycles, abort on the next
    run_vec(v(1, 8'h13, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'hF0, 8'hA5));
    run_vec(v(1, 8'h13, 0, 0, 4'h0, 1, 0, 0, 0, 0, 8'h13, 8'hA5));
    for (int k = 0; k < 15; k++)
      run_vec(v(1, 8'h13, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h13, 8'hA5));
    run_vec(v(1, 8'h13, 0, 0, 4'h1, 0, 0, 0, 1, 0, 8'h13, 8'hA5));
    run_vec(v(1, 8'h14, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h13, 8'hA5));

    // done arriving on the timeout cycle wins
    run_vec(v(1, 8'h14, 0, 0, 4'h0, 1, 0, 0, 0, 0, 8'h14, 8'hA5));
    for (int k = 0; k < 15; k++)
      run_vec(v(1, 8'h14, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h14, 8'hA5));
    run_vec(v(1, 8'h14, 0, 1, 4'h1, 0, 1, 0, 0, 0, 8'h14, 8'hA5));

    // HALT holds indefinitely
    run_vec(v(1, 8'h70, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h14, 8'hA5));
    run_vec(v(1, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h70, 8'hA5));
    for (int k = 0; k < 20; k++)
      run_vec(v(1, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h70, 8'hA5));
    run_vec(v(0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h70, 8'hA5));

    // reset while waiting on the ALU suppresses the write
    run_vec(v(1, 8'h11, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    run_vec(v(1, 8'h11, 0, 0, 4'h0, 1, 0, 0, 0, 0, 8'h11, 8'h00));
    run_vec(v(1, 8'h11, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h11, 8'h00));
    run_vec(v(0, 8'h11, 0, 1, 4'h0, 0, 0, 0, 0, 0, 8'h11, 8'h00));
    run_vec(v(1, 8'h00, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    run_vec(v(1, 8'h00, 0, 0, 4'h1, 0, 0, 0, 0, 0, 8'h00, 8'h00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
- Instruction sequencer for the MicroUAZ8 core.
- Fetches the 8-bit instruction byte addressed by the program counter unit and classifies it.
- Drives the PC unit's 4-bit jump-control code (CJ) and sequences ALU start/done and register-write strobes.
- Sits between instruction memory, the PC/jump unit and the datapath; the only source of CJ.

Parameters:
- ALU_TIMEOUT, 15: max cycles waited for i_Alu_Done before abort; 4-bit counter width.

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  synchronous, active-low reset
- i_Instr  in  8  byte on instruction bus (at current PC)
- i_Stall  in  1  instruction memory not ready; hold fetch
- i_Alu_Done  in  1  ALU result valid, one-cycle pulse
- o_CJ  out  4  jump-control code to PC unit
- o_IR  out  8  latched instruction register
- o_Imm  out  8  latched immediate operand
- o_Alu_Start  out  1  one-cycle ALU start pulse
- o_Reg_We  out  1  one-cycle register-file write strobe
- o_Wr_Sel  out  1  write source: 0 = ALU, 1 = o_Imm
- o_Illegal  out  1  one-cycle pulse on undefined opcode or ALU timeout
- o_Halted  out  1  high while in HALT

Behaviour:
- Reset (Rst==0 at a Clk edge):
  - state=FETCH; o_IR=0x00; o_Imm=0x00; timeout counter=0.
  - All pulse outputs and o_Halted are 0.
  - o_CJ is forced to 0000 combinationally while Rst==0.
- CJ codes:
  - 0000 hold; 0001 increment.
  - 1000/1001 unconditional jump.
  - 1010/1011 jump on Flags[0] set/clear.
  - 1100/1101 jump on Flags[2] set/clear.
  - 1110/1111 jump on Flags[1] set/clear.
- Opcode class = IR[7:4]:
  - 0x0 NOP; 0x1 ALU; 0x2 LDI (two bytes); 0x7 HALT.
  - 0x8..0xF jump, with CJ = IR[7:4].
  - 0x3..0x6 illegal.
- FETCH: o_CJ=0000. If i_Stall=1, stay. Else IR<=i_Instr, go to DECODE.
- DECODE:
  - NOP: o_CJ=0001 -> FETCH.
  - Jump: o_CJ=IR[7:4] -> FETCH. The PC unit resolves the condition and falls through to PC+1 when not taken.
  - ALU: o_CJ=0000, o_Alu_Start=1, counter cleared -> WAIT_ALU.
  - LDI: o_CJ=0001 -> OPERAND.
  - HALT: o_CJ=0000 -> HALT.
  - Illegal: o_Illegal=1, o_CJ=0001 (treated as NOP) -> FETCH.
- WAIT_ALU:
  - o_CJ=0000; counter increments each cycle.
  - On i_Alu_Done: o_Reg_We=1, o_Wr_Sel=0, o_CJ=0001 -> FETCH.
  - If counter reaches ALU_TIMEOUT with no done: o_Illegal=1, o_CJ=0001, no write -> FETCH.
  - Done and timeout in the same cycle: done wins.
- OPERAND: o_CJ=0000. If i_Stall=1, stay. Else o_Imm<=i_Instr -> WRITE_IMM.
- WRITE_IMM: o_Reg_We=1, o_Wr_Sel=1, o_CJ=0001 -> FETCH.
- HALT: o_CJ=0000, o_Halted=1; exited only by reset.
- Latency in cycles: NOP/jump/illegal 2; ALU 3 + wait; LDI 4 with no stall.
- PC advances exactly once per byte consumed. No CJ other than 0000 is issued while stalled.
- o_Alu_Start, o_Reg_We and o_Illegal are never high for more than one consecutive cycle.
- Reset mid-instruction: abandons the instruction and suppresses any pending write.
- Undefined state encodings recover to FETCH.

Optional Feature:
- Macro: SEQ_CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input i_Step (1 bit) and state STEP.
  - After each retiring transition to FETCH, the FSM goes instead to STEP (o_CJ=0000) and waits for i_Step=1, then proceeds to FETCH.
  - HALT is unaffected.
- Undefined: no i_Step port, no STEP state; timing exactly as above.

Decomposition:
- Shared package ctrl_pkg holds:
  - state typedef (FETCH, DECODE, WAIT_ALU, OPERAND, WRITE_IMM, HALT, STEP).
  - CJ code constants (CJ_HOLD, CJ_INC, CJ_JMP...).
  - opcode-class constants.
- One natural sub-module, op_decode (combinational): IR[7:4] -> class (nop/alu/ldi/halt/jump/illegal).

Test Plan:
- Rst low 2 cycles, release, i_Instr=0x00 -> o_CJ: 0000, then 0001, repeating with 2-cycle period; o_IR=0x00.
- i_Instr=0x1x, i_Alu_Done pulsed 3 cycles after o_Alu_Start:
  - o_Alu_Start one cycle; o_CJ=0000 through wait.
  - Done cycle shows o_Reg_We=1, o_Wr_Sel=0, o_CJ=0001.
- LDI 0x25 then operand 0xA5, i_Stall=1 for 2 cycles in OPERAND:
  - o_CJ sequence 0000, 0001, 0000 x3, 0001.
  - o_Imm=0xA5; o_Reg_We with o_Wr_Sel=1.
- i_Instr=0xA3 -> o_CJ=1010 in DECODE. Repeat with 0x83 -> o_CJ=1000. Then 0x50 -> o_Illegal pulse, o_CJ=0001.
- ALU with i_Alu_Done never asserted -> after 15 wait cycles: o_Illegal=1, o_CJ=0001, o_Reg_We stays 0.
- i_Instr=0x70 -> o_Halted=1 and o_CJ=0000 indefinitely. Rst low during WAIT_ALU -> no o_Reg_We, state FETCH.
